ralu_sequencer: RTL and testbench

Control-side initiator for the RALU datapath. It accepts one macro-instruction per start/ready handshake and expands it into a fixed sequence of registered RALU control words: DataIn, S, M, Pin, ISR, ISL, A, wr, adr and v. It captures the RALU Pout and R results into status flags, and sits between the instruction decoder and the RALU inside the central unit.

---
 rtl/ralu_sequencer_if.sv | 41 ++++
 rtl/ralu_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_ralu_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ralu_sequencer_if.sv
// Handshake and RALU control/result bundle between the instruction decoder,
// the sequencer and the RALU datapath.
interface ralu_sequencer_if #(
  parameter int WIDTH      = 4,
  parameter int ADDR_WIDTH = 3
);
  logic                  start;
  logic [2:0]            opcode;
  logic [ADDR_WIDTH-1:0] dst;
  logic [ADDR_WIDTH-1:0] src;
  logic [WIDTH-1:0]      imm;
  logic                  Pout;
  logic [WIDTH-1:0]      R;
  logic                  ready;
  logic                  done;
  logic                  err;
  logic                  carry;
  logic                  zero;
  logic [WIDTH-1:0]      DataIn;
  logic [3:0]            S;
  logic                  M;
  logic                  Pin;
  logic                  ISR;
  logic                  ISL;
  logic                  A;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] adr;
  logic [3:0]            v;

  modport master (
    output start, opcode, dst, src, imm, Pout, R,
    input  ready, done, err, carry, zero,
    input  DataIn, S, M, Pin, ISR, ISL, A, wr, adr, v
  );

  modport slave (
    input  start, opcode, dst, src, imm, Pout, R,
    output ready, done, err, carry, zero,
    output DataIn, S, M, Pin, ISR, ISL, A, wr, adr, v
  );
endinterface

// File: rtl/ralu_sequencer.sv
// Expands one macro-instruction per start/ready handshake into a sequence of
// registered RALU control words and captures the RALU result flags.
module ralu_sequencer #(
  parameter int WIDTH      = 4,
  parameter int ADDR_WIDTH = 3
) (
  input  logic            clock,
  input  logic            reset,
  ralu_sequencer_if.slave bus
);
  // state | meaning
  // IDLE  | ready=1, idle word, waiting for start
  // EXEC  | one control word per clock; step_q is the step being driven
  // DONE  | done pulse with the idle word, then back to IDLE
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [2:0] OP_LDI = 3'b001;
  localparam logic [2:0] OP_MOV = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;

  typedef struct packed {
    logic [WIDTH-1:0]      data_in;
    logic [3:0]            s;
    logic                  m;
    logic                  a;
    logic                  wr;
    logic [ADDR_WIDTH-1:0] adr;
    logic [3:0]            v;
  } word_t;

  function automatic logic [2:0] steps_for(input logic [2:0] op, input logic [1:0] sh);
    logic [2:0] n;
    case (op)
      OP_LDI, OP_MOV: n = 3'd2;
      OP_ADD, OP_AND: n = 3'd3;
      OP_SHL:         n = 3'd2 + {1'b0, sh};
      default:        n = 3'd0;
    endcase
    return n;
  endfunction

  function automatic word_t word_for(input logic [2:0]            op,
                                     input logic [ADDR_WIDTH-1:0] d,
                                     input logic [ADDR_WIDTH-1:0] s_reg,
                                     input logic [WIDTH-1:0]      im,
                                     input logic [2:0]            step,
                                     input logic                  last);
    word_t w;
    w = '0;
    case (op)
      OP_LDI: begin
        if (step == 3'd1) begin
          w.a = 1'b1; w.data_in = im; w.v = 4'b0001;
        end else begin
          w.wr = 1'b1; w.adr = d;
        end
      end
      OP_MOV: begin
        if (step == 3'd1) begin
          w.adr = s_reg; w.v = 4'b0001;
        end else begin
          w.wr = 1'b1; w.adr = d;
        end
      end
      OP_ADD, OP_AND: begin
        if (step == 3'd1) begin
          w.adr = d; w.v = 4'b0001;
        end else if (step == 3'd2) begin
          w.adr = s_reg; w.v = 4'b0110;
        end else begin
          w.s   = (op == OP_ADD) ? 4'b1001 : 4'b0100;
          w.m   = (op == OP_ADD);
          w.wr  = 1'b1;
          w.adr = d;
        end
      end
      OP_SHL: begin
        w.adr = d;
        if (step == 3'd1) begin
          w.v = 4'b0110;
        end else begin
          w.s = 4'b0101; w.v = 4'b0010; w.wr = last;
        end
      end
      default: w = '0;
    endcase
    return w;
  endfunction

  state_t                state_q, state_d;
  logic [2:0]            step_q, step_d, nsteps_q, nsteps_d, op_q, op_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d, src_q, src_d;
  logic [WIDTH-1:0]      imm_q, imm_d;
  word_t                 word_q, word_d;
  logic                  ready_q, ready_d, done_q, done_d, err_q, err_d;
  logic                  carry_q, carry_d, zero_q, zero_d;
  logic [2:0]            n_in, step_nx;

  assign n_in    = steps_for(bus.opcode, bus.imm[1:0]);
  assign step_nx = step_q + 3'd1;

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    nsteps_d = nsteps_q;
    op_d     = op_q;
    dst_d    = dst_q;
    src_d    = src_q;
    imm_d    = imm_q;
    word_d   = word_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    err_d    = err_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (bus.start && ready_q) begin
          op_d     = bus.opcode;
          dst_d    = bus.dst;
          src_d    = bus.src;
          imm_d    = bus.imm;
          nsteps_d = n_in;
          step_d   = 3'd1;
          ready_d  = 1'b0;
          err_d    = (bus.opcode > OP_SHL);
          // NOP and illegal opcodes have no steps and finish immediately
          if (n_in == 3'd0) begin
            state_d = DONE;
            done_d  = 1'b1;
            word_d  = '0;
          end else begin
            state_d = EXEC;
            word_d  = word_for(bus.opcode, bus.dst, bus.src, bus.imm, 3'd1, n_in == 3'd1);
          end
        end
      end
      EXEC: begin
        if (step_q == nsteps_q) begin
          state_d = DONE;
          done_d  = 1'b1;
          word_d  = '0;
          if (op_q == OP_ADD) carry_d = bus.Pout;
          if (op_q == OP_ADD || op_q == OP_AND || op_q == OP_SHL) zero_d = (bus.R == '0);
        end else begin
          step_d = step_nx;
          word_d = word_for(op_q, dst_q, src_q, imm_q, step_nx, step_nx == nsteps_q);
        end
      end
      DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
        word_d  = '0;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        word_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      step_q   <= '0;
      nsteps_q <= '0;
      op_q     <= '0;
      dst_q    <= '0;
      src_q    <= '0;
      imm_q    <= '0;
      word_q   <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      nsteps_q <= nsteps_d;
      op_q     <= op_d;
      dst_q    <= dst_d;
      src_q    <= src_d;
      imm_q    <= imm_d;
      word_q   <= word_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      err_q    <= err_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.ready  = ready_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.carry  = carry_q;
  assign bus.zero   = zero_q;
  assign bus.DataIn = word_q.data_in;
  assign bus.S      = word_q.s;
  assign bus.M      = word_q.m;
  assign bus.A      = word_q.a;
  assign bus.wr     = word_q.wr;
  assign bus.adr    = word_q.adr;
  assign bus.v      = word_q.v;
  assign bus.Pin    = 1'b0;
  assign bus.ISR    = 1'b0;
  assign bus.ISL    = 1'b0;
endmodule

// File: tb/tb_ralu_sequencer.sv
// Self-checking bench for ralu_sequencer: directed scenarios plus randomized
// instructions checked against a step-list reference model.
module tb_ralu_sequencer;
  localparam int WIDTH      = 4;
  localparam int ADDR_WIDTH = 3;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LDI = 3'd1;
  localparam logic [2:0] OP_MOV = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [3:0] Z4 = 4'd0;
  localparam logic [2:0] Z3 = 3'd0;

  typedef struct packed {
    logic [3:0] data_in;
    logic [3:0] s;
    logic       m;
    logic       a;
    logic       wr;
    logic [2:0] adr;
    logic [3:0] v;
    logic       pin;
    logic       isr;
    logic       isl;
  } tw_t;

  typedef struct packed {
    logic ready;
    logic done;
    tw_t  w;
  } cyc_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  ralu_sequencer_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  ralu_sequencer #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int   n_checks = 0;
  int   n_fail   = 0;
  tw_t  obs_q[$];
  logic obs_ready_q[$];
  tw_t  exp_q[$];
  int   obs_done_idx;
  logic ready_after, done_after;
  bit   timed_out;
  logic m_carry = 1'b0, m_zero = 1'b0, m_err = 1'b0;

  function automatic tw_t mk(input logic [3:0] din, input logic [3:0] s, input logic m,
                             input logic a, input logic wr, input logic [2:0] adr,
                             input logic [3:0] v);
    tw_t w;
    w = '0;
    w.data_in = din; w.s = s; w.m = m; w.a = a; w.wr = wr; w.adr = adr; w.v = v;
    return w;
  endfunction

  function automatic tw_t get_word();
    tw_t w;
    w.data_in = bus.DataIn; w.s = bus.S; w.m = bus.M; w.a = bus.A; w.wr = bus.wr;
    w.adr = bus.adr; w.v = bus.v; w.pin = bus.Pin; w.isr = bus.ISR; w.isl = bus.ISL;
    return w;
  endfunction

  // Reference step list for one instruction, written straight from the step table
  task automatic build_exp(input logic [2:0] op, input logic [2:0] d, input logic [2:0] sr,
                           input logic [3:0] im);
    int shifts;
    exp_q.delete();
    shifts = int'(im[1:0]) + 1;
    case (op)
      OP_LDI: begin
        exp_q.push_back(mk(im, Z4, 1'b0, 1'b1, 1'b0, Z3, 4'b0001));
        exp_q.push_back(mk(Z4, Z4, 1'b0, 1'b0, 1'b1, d, Z4));
      end
      OP_MOV: begin
        exp_q.push_back(mk(Z4, Z4, 1'b0, 1'b0, 1'b0, sr, 4'b0001));
        exp_q.push_back(mk(Z4, Z4, 1'b0, 1'b0, 1'b1, d, Z4));
      end
      OP_ADD, OP_AND: begin
        exp_q.push_back(mk(Z4, Z4, 1'b0, 1'b0, 1'b0, d, 4'b0001));
        exp_q.push_back(mk(Z4, Z4, 1'b0, 1'b0, 1'b0, sr, 4'b0110));
        if (op == OP_ADD) exp_q.push_back(mk(Z4, 4'b1001, 1'b1, 1'b0, 1'b1, d, Z4));
        else              exp_q.push_back(mk(Z4, 4'b0100, 1'b0, 1'b0, 1'b1, d, Z4));
      end
      OP_SHL: begin
        exp_q.push_back(mk(Z4, Z4, 1'b0, 1'b0, 1'b0, d, 4'b0110));
        for (int i = 1; i <= shifts; i++)
          exp_q.push_back(mk(Z4, 4'b0101, 1'b0, 1'b0, (i == shifts), d, 4'b0010));
      end
      default: ;
    endcase
  endtask

  task automatic model_update(input logic [2:0] op, input logic [3:0] r, input logic p);
    if (op == OP_ADD) m_carry = p;
    if (op == OP_ADD || op == OP_AND || op == OP_SHL) m_zero = (r == 4'd0);
    m_err = (op > OP_SHL);
  endtask

  // Issues one instruction from a negedge and records one word per cycle until done
  task automatic run_instr(input logic [2:0] op, input logic [2:0] d, input logic [2:0] sr,
                           input logic [3:0] im, input bit poke_mid);
    int guard;
    guard = 0;
    obs_q.delete(); obs_ready_q.delete();
    obs_done_idx = -1; timed_out = 1'b0; ready_after = 1'b0; done_after = 1'b1;
    while (bus.ready !== 1'b1 && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (bus.ready !== 1'b1) begin
      timed_out = 1'b1;
      return;
    end
    bus.start = 1'b1; bus.opcode = op; bus.dst = d; bus.src = sr; bus.imm = im;
    @(negedge clock);
    bus.start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      obs_q.push_back(get_word());
      obs_ready_q.push_back(bus.ready);
      if (bus.done === 1'b1) begin
        obs_done_idx = i;
        break;
      end
      if (poke_mid && i == 2) begin
        bus.start = 1'b1; bus.opcode = OP_LDI; bus.imm = 4'hF;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clock);
    end
    bus.start = 1'b0;
    if (obs_done_idx < 0) timed_out = 1'b1;
    else begin
      @(negedge clock);
      ready_after = bus.ready;
      done_after  = bus.done;
    end
  endtask

  task automatic test_reset();
    n_checks++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.ready); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_checks++; if ({bus.err, bus.carry, bus.zero} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {bus.err, bus.carry, bus.zero}); end
    n_checks++; if (get_word() !== tw_t'(0)) begin n_fail++; $display("FAIL reset_word: got %h expected 0", get_word()); end
  endtask

  task automatic test_ldi();
    bus.R = 4'd7; bus.Pout = 1'b0;
    run_instr(OP_LDI, 3'd0, 3'd0, 4'd3, 1'b0);
    model_update(OP_LDI, 4'd7, 1'b0);
    n_checks++; if (obs_done_idx != 3) begin n_fail++; $display("FAIL ldi0_done_cycle: got %0d expected 3", obs_done_idx); end
    if (obs_q.size() >= 3) begin
      n_checks++; if (obs_q[0] !== mk(4'd3, Z4, 1'b0, 1'b1, 1'b0, Z3, 4'b0001)) begin n_fail++; $display("FAIL ldi0_step1: got %h", obs_q[0]); end
      n_checks++; if (obs_q[1] !== mk(Z4, Z4, 1'b0, 1'b0, 1'b1, 3'd0, Z4)) begin n_fail++; $display("FAIL ldi0_step2: got %h", obs_q[1]); end
      n_checks++; if (obs_q[2] !== tw_t'(0)) begin n_fail++; $display("FAIL ldi0_done_word: got %h expected 0", obs_q[2]); end
      n_checks++; if ({obs_ready_q[0], obs_ready_q[1], obs_ready_q[2]} !== 3'b000) begin n_fail++; $display("FAIL ldi0_ready_busy: got %b expected 000", {obs_ready_q[0], obs_ready_q[1], obs_ready_q[2]}); end
    end
    n_checks++; if ({ready_after, done_after} !== 2'b10) begin n_fail++; $display("FAIL ldi0_ready_return: got %b expected 10", {ready_after, done_after}); end
    run_instr(OP_LDI, 3'd1, 3'd0, 4'd12, 1'b0);
    model_update(OP_LDI, 4'd7, 1'b0);
    n_checks++; if (obs_done_idx != 3) begin n_fail++; $display("FAIL ldi1_done_cycle: got %0d expected 3", obs_done_idx); end
    if (obs_q.size() >= 2) begin
      n_checks++; if (obs_q[0] !== mk(4'd12, Z4, 1'b0, 1'b1, 1'b0, Z3, 4'b0001)) begin n_fail++; $display("FAIL ldi1_step1: got %h", obs_q[0]); end
      n_checks++; if (obs_q[1] !== mk(Z4, Z4, 1'b0, 1'b0, 1'b1, 3'd1, Z4)) begin n_fail++; $display("FAIL ldi1_step2: got %h", obs_q[1]); end
    end
  endtask

  task automatic test_add();
    bus.R = 4'd15; bus.Pout = 1'b0;
    run_instr(OP_ADD, 3'd1, 3'd0, 4'd0, 1'b0);
    model_update(OP_ADD, 4'd15, 1'b0);
    n_checks++; if (obs_done_idx != 4) begin n_fail++; $display("FAIL add_done_cycle: got %0d expected 4", obs_done_idx); end
    if (obs_q.size() >= 3) begin
      n_checks++; if (obs_q[0] !== mk(Z4, Z4, 1'b0, 1'b0, 1'b0, 3'd1, 4'b0001)) begin n_fail++; $display("FAIL add_step1: got %h", obs_q[0]); end
      n_checks++; if (obs_q[1] !== mk(Z4, Z4, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0110)) begin n_fail++; $display("FAIL add_step2: got %h", obs_q[1]); end
      n_checks++; if (obs_q[2] !== mk(Z4, 4'b1001, 1'b1, 1'b0, 1'b1, 3'd1, Z4)) begin n_fail++; $display("FAIL add_step3: got %h", obs_q[2]); end
    end
    n_checks++; if ({bus.carry, bus.zero} !== 2'b00) begin n_fail++; $display("FAIL add_flags_r15: got %b expected 00", {bus.carry, bus.zero}); end
    bus.R = 4'd0; bus.Pout = 1'b1;
    run_instr(OP_ADD, 3'd1, 3'd0, 4'd0, 1'b0);
    model_update(OP_ADD, 4'd0, 1'b1);
    n_checks++; if ({bus.carry, bus.zero} !== 2'b11) begin n_fail++; $display("FAIL add_flags_r0: got %b expected 11", {bus.carry, bus.zero}); end
    bus.R = 4'd5; bus.Pout = 1'b0;
    run_instr(OP_AND, 3'd4, 3'd6, 4'd0, 1'b0);
    model_update(OP_AND, 4'd5, 1'b0);
    n_checks++; if (obs_q.size() < 3 || obs_q[2] !== mk(Z4, 4'b0100, 1'b0, 1'b0, 1'b1, 3'd4, Z4)) begin n_fail++; $display("FAIL and_step3: got %h", obs_q.size() >= 3 ? obs_q[2] : tw_t'(0)); end
    n_checks++; if ({bus.carry, bus.zero} !== 2'b10) begin n_fail++; $display("FAIL and_flags: got %b expected 10 (carry held)", {bus.carry, bus.zero}); end
  endtask

  task automatic test_shl();
    bus.R = 4'd0; bus.Pout = 1'b0;
    run_instr(OP_SHL, 3'd0, 3'd3, 4'b0010, 1'b1);
    model_update(OP_SHL, 4'd0, 1'b0);
    n_checks++; if (obs_done_idx != 5) begin n_fail++; $display("FAIL shl_done_cycle: got %0d expected 5", obs_done_idx); end
    if (obs_q.size() >= 5) begin
      n_checks++; if (obs_q[0] !== mk(Z4, Z4, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0110)) begin n_fail++; $display("FAIL shl_load: got %h", obs_q[0]); end
      for (int i = 1; i <= 3; i++) begin
        n_checks++;
        if (obs_q[i] !== mk(Z4, 4'b0101, 1'b0, 1'b0, (i == 3), 3'd0, 4'b0010)) begin
          n_fail++; $display("FAIL shl_shift%0d: got %h", i, obs_q[i]);
        end
      end
      n_checks++; if (obs_q[4] !== tw_t'(0)) begin n_fail++; $display("FAIL shl_done_word: got %h expected 0", obs_q[4]); end
    end
    n_checks++; if (bus.zero !== 1'b1) begin n_fail++; $display("FAIL shl_zero: got %b expected 1", bus.zero); end
    n_checks++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL shl_no_extra_accept: ready got %b expected 1", bus.ready); end
  endtask

  task automatic test_illegal();
    run_instr(3'b111, 3'd2, 3'd2, 4'd9, 1'b0);
    model_update(3'b111, 4'd0, 1'b0);
    n_checks++; if (obs_done_idx != 1) begin n_fail++; $display("FAIL illegal_done_cycle: got %0d expected 1", obs_done_idx); end
    n_checks++; if (obs_q.size() < 1 || obs_q[0] !== tw_t'(0)) begin n_fail++; $display("FAIL illegal_word: got %h expected 0", obs_q.size() >= 1 ? obs_q[0] : tw_t'(0)); end
    repeat (3) @(negedge clock);
    n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL illegal_err_sticky: got %b expected 1", bus.err); end
    run_instr(OP_LDI, 3'd2, 3'd0, 4'd5, 1'b0);
    model_update(OP_LDI, 4'd0, 1'b0);
    n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL illegal_err_clear: got %b expected 0", bus.err); end
  endtask

  task automatic test_reset_mid_add();
    bus.R = 4'd0; bus.Pout = 1'b1;
    run_instr(OP_ADD, 3'd2, 3'd3, 4'd0, 1'b0);
    model_update(OP_ADD, 4'd0, 1'b1);
    n_checks++; if ({bus.carry, bus.zero} !== 2'b11) begin n_fail++; $display("FAIL midrst_pre_flags: got %b expected 11", {bus.carry, bus.zero}); end
    bus.start = 1'b1; bus.opcode = OP_ADD; bus.dst = 3'd1; bus.src = 3'd5;
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    n_checks++; if (get_word() !== mk(Z4, Z4, 1'b0, 1'b0, 1'b0, 3'd5, 4'b0110)) begin n_fail++; $display("FAIL midrst_step2: got %h", get_word()); end
    #1 reset = 1'b1;
    #1;
    n_checks++; if (get_word() !== tw_t'(0)) begin n_fail++; $display("FAIL midrst_word: got %h expected 0", get_word()); end
    n_checks++; if ({bus.ready, bus.done, bus.err, bus.carry, bus.zero} !== 5'b10000) begin n_fail++; $display("FAIL midrst_status: got %b expected 10000", {bus.ready, bus.done, bus.err, bus.carry, bus.zero}); end
    @(negedge clock);
    reset = 1'b0;
    m_carry = 1'b0; m_zero = 1'b0; m_err = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      n_checks++;
      if ({bus.ready, bus.done, get_word()} !== {1'b1, 1'b0, tw_t'(0)}) begin
        n_fail++; $display("FAIL midrst_after%0d: ready/done/word got %b/%b/%h expected 1/0/0", i, bus.ready, bus.done, get_word());
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops[8], ds[8], ss[8];
    logic [3:0] ims[8], rs[8];
    logic       ps[8];
    cyc_t       exp_tr[$];
    cyc_t       got;
    int         idx;
    for (int j = 0; j < 8; j++) begin
      ops[j] = 3'($urandom_range(0, 7)); ds[j] = 3'($urandom_range(0, 7));
      ss[j] = 3'($urandom_range(0, 7)); ims[j] = 4'($urandom_range(0, 15));
      rs[j] = 4'($urandom_range(0, 3)); ps[j] = 1'($urandom_range(0, 1));
    end
    ops[2] = 3'b110; ops[3] = OP_NOP; ops[5] = OP_SHL; ims[5] = 4'b0011;
    for (int j = 0; j < 8; j++) begin
      build_exp(ops[j], ds[j], ss[j], ims[j]);
      exp_tr.push_back('{ready: 1'b1, done: 1'b0, w: tw_t'(0)});
      foreach (exp_q[k]) exp_tr.push_back('{ready: 1'b0, done: 1'b0, w: exp_q[k]});
      exp_tr.push_back('{ready: 1'b0, done: 1'b1, w: tw_t'(0)});
      model_update(ops[j], rs[j], ps[j]);
    end
    exp_tr.push_back('{ready: 1'b1, done: 1'b0, w: tw_t'(0)});
    idx = 0;
    foreach (exp_tr[c]) begin
      got = '{ready: bus.ready, done: bus.done, w: get_word()};
      n_checks++;
      if (got !== exp_tr[c]) begin
        n_fail++; $display("FAIL b2b_cycle%0d: ready/done/word got %b/%b/%h expected %b/%b/%h", c, got.ready, got.done, got.w, exp_tr[c].ready, exp_tr[c].done, exp_tr[c].w);
      end
      if (bus.ready === 1'b1) begin
        if (idx < 8) begin
          bus.start = 1'b1; bus.opcode = ops[idx]; bus.dst = ds[idx]; bus.src = ss[idx];
          bus.imm = ims[idx]; bus.R = rs[idx]; bus.Pout = ps[idx];
          idx++;
        end else begin
          bus.start = 1'b0;
        end
      end
      @(negedge clock);
    end
    bus.start = 1'b0;
    n_checks++; if ({bus.err, bus.carry, bus.zero} !== {m_err, m_carry, m_zero}) begin n_fail++; $display("FAIL b2b_flags: got %b expected %b", {bus.err, bus.carry, bus.zero}, {m_err, m_carry, m_zero}); end
  endtask

  task automatic test_random();
    logic [2:0] op, d, sr;
    logic [3:0] im, r;
    logic       p;
    for (int t = 0; t < 25; t++) begin
      op = 3'($urandom_range(0, 7)); d = 3'($urandom_range(0, 7)); sr = 3'($urandom_range(0, 7));
      im = 4'($urandom_range(0, 15)); r = 4'($urandom_range(0, 2)); p = 1'($urandom_range(0, 1));
      bus.R = r; bus.Pout = p;
      build_exp(op, d, sr, im);
      model_update(op, r, p);
      run_instr(op, d, sr, im, 1'b0);
      n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL rand%0d_timeout: got %b expected 0", t, timed_out); end
      n_checks++; if (obs_done_idx != exp_q.size() + 1) begin n_fail++; $display("FAIL rand%0d_done_cycle op=%0d: got %0d expected %0d", t, op, obs_done_idx, exp_q.size() + 1); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i] || obs_ready_q[i] !== 1'b0) begin
          n_fail++; $display("FAIL rand%0d_step%0d op=%0d: word/ready got %h/%b expected %h/0", t, i + 1, op, obs_q[i], obs_ready_q[i], exp_q[i]);
        end
      end
      n_checks++; if ({ready_after, done_after} !== 2'b10) begin n_fail++; $display("FAIL rand%0d_ready_return: got %b expected 10", t, {ready_after, done_after}); end
      n_checks++; if ({bus.err, bus.carry, bus.zero} !== {m_err, m_carry, m_zero}) begin n_fail++; $display("FAIL rand%0d_flags op=%0d: got %b expected %b", t, op, {bus.err, bus.carry, bus.zero}, {m_err, m_carry, m_zero}); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit expected test completion");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0; bus.opcode = 3'd0; bus.dst = 3'd0; bus.src = 3'd0;
    bus.imm = 4'd0; bus.R = 4'd0; bus.Pout = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    test_reset();
    reset = 1'b0;
    @(negedge clock);
    test_ldi();
    test_add();
    test_shl();
    test_illegal();
    test_reset_mid_add();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
